// File: rtl/gpio_seq_pkg.sv
// Shared register map, CSR bit positions and FSM encoding for the gpio_seq
// pattern sequencer.
package gpio_seq_pkg;

    localparam logic [1:0] ADDR_CSR    = 2'd0;
    localparam logic [1:0] ADDR_FIFO   = 2'd1;
    localparam logic [1:0] ADDR_OEMASK = 2'd2;

    localparam int CSR_EN         = 0;
    localparam int CSR_FLUSH      = 1;
    localparam int CSR_DONE_IE    = 2;
    localparam int CSR_OVF_IE     = 3;
    localparam int CSR_BUSY       = 8;
    localparam int CSR_FULL       = 9;
    localparam int CSR_EMPTY      = 10;
    localparam int CSR_DONE       = 12;
    localparam int CSR_OVF        = 13;
    localparam int CSR_LEVEL_LSB  = 16;
    localparam int CSR_LEVEL_W    = 5;
    localparam int FIFO_DELAY_LSB = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } seq_state_e;

    function automatic logic [31:0] csr_word(
        input logic                   en,
        input logic                   done_ie,
        input logic                   ovf_ie,
        input logic                   busy,
        input logic                   full,
        input logic                   empty,
        input logic                   done,
        input logic                   ovf,
        input logic [CSR_LEVEL_W-1:0] level
    );
        logic [31:0] v;
        v = '0;
        v[CSR_EN]      = en;
        v[CSR_DONE_IE] = done_ie;
        v[CSR_OVF_IE]  = ovf_ie;
        v[CSR_BUSY]    = busy;
        v[CSR_FULL]    = full;
        v[CSR_EMPTY]   = empty;
        v[CSR_DONE]    = done;
        v[CSR_OVF]     = ovf;
        v[CSR_LEVEL_LSB +: CSR_LEVEL_W] = level;
        return v;
    endfunction

endpackage

// File: rtl/gpio_seq_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is taken
// only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_level == '0);
    assign full      = (r_level == LVL_FULL);
    assign level     = r_level;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

    // Storage needs no reset: the pointers and level decide what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/gpio_seq.sv
// Timed GPIO pattern sequencer: APB register block, (value, delay) FIFO and a
// two-state replay FSM that holds each value for delay+1 cycles.
module gpio_seq
    import gpio_seq_pkg::*;
#(
    parameter int N_GPIOS = 8,
    parameter int DEPTH   = 8,
    parameter int DELAY_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               apbs_psel,
    input  logic               apbs_penable,
    input  logic               apbs_pwrite,
    input  logic [15:0]        apbs_paddr,
    input  logic [31:0]        apbs_pwdata,
    output logic [31:0]        apbs_prdata,
    output logic               apbs_pready,
    output logic               apbs_pslverr,
    output logic [N_GPIOS-1:0] seq_o,
    output logic [N_GPIOS-1:0] seq_oe,
    output logic               seq_active,
    output logic               irq,
    output seq_state_e         dbg_state
);

    localparam int EW = N_GPIOS + DELAY_W;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [1:0]         w_addr;
    logic               w_wr;
    logic               w_csr_wr;
    logic               w_fifo_wr;
    logic               w_oem_wr;
    logic               w_flush;
    logic               w_pop;
    logic               w_done_set;
    logic               w_ovf_set;
    logic               w_full;
    logic               w_empty;
    logic [LW-1:0]      w_level;
    logic [EW-1:0]      w_fifo_wdata;
    logic [EW-1:0]      w_fifo_rdata;
    logic               w_unused;

    seq_state_e         r_state;
    seq_state_e         w_state_nxt;
    logic [DELAY_W-1:0] r_cnt;
    logic [N_GPIOS-1:0] r_seq_o;
    logic [N_GPIOS-1:0] r_oemask;
    logic               r_en;
    logic               r_done_ie;
    logic               r_ovf_ie;
    logic               r_done;
    logic               r_ovf;

    // APB: writes commit in the access phase; reads are combinational.
    assign w_addr       = apbs_paddr[3:2];
    assign w_wr         = apbs_psel & apbs_penable & apbs_pwrite;
    assign w_csr_wr     = w_wr & (w_addr == ADDR_CSR);
    assign w_fifo_wr    = w_wr & (w_addr == ADDR_FIFO);
    assign w_oem_wr     = w_wr & (w_addr == ADDR_OEMASK);
    assign w_flush      = w_csr_wr & apbs_pwdata[CSR_FLUSH];
    assign w_ovf_set    = w_fifo_wr & w_full & ~w_pop;
    assign w_fifo_wdata = {apbs_pwdata[FIFO_DELAY_LSB +: DELAY_W], apbs_pwdata[N_GPIOS-1:0]};
    assign w_unused     = ^{apbs_paddr[15:4], apbs_paddr[1:0], apbs_pwdata};

    assign apbs_pready  = 1'b1;
    assign apbs_pslverr = 1'b0;
    assign seq_o        = r_seq_o;
    assign seq_oe       = r_oemask;
    assign seq_active   = r_en;
    assign irq          = (r_done & r_done_ie) | (r_ovf & r_ovf_ie);
    assign dbg_state    = r_state;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_fifo_wr),
        .pop   (w_pop),
        .flush (w_flush),
        .wdata (w_fifo_wdata),
        .rdata (w_fifo_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_en && !w_empty) w_state_nxt = ST_HOLD;
            ST_HOLD: if (!r_en || (r_cnt == '0 && w_empty)) w_state_nxt = ST_IDLE;
        endcase
    end

    // A finished entry is chained straight into the next one with no gap.
    always_comb begin
        w_pop      = 1'b0;
        w_done_set = 1'b0;
        case (r_state)
            ST_IDLE: w_pop = r_en & ~w_empty;
            ST_HOLD: begin
                w_pop      = r_en & (r_cnt == '0) & ~w_empty;
                w_done_set = r_en & (r_cnt == '0) & w_empty;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq_o <= '0;
            r_cnt   <= '0;
        end else if (w_pop) begin
            r_seq_o <= w_fifo_rdata[N_GPIOS-1:0];
            r_cnt   <= w_fifo_rdata[EW-1:N_GPIOS];
        end else if (!r_en) begin
            r_cnt <= '0;
        end else if (r_state == ST_HOLD && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Sticky flags: a set event in the same cycle as W1C wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en      <= 1'b0;
            r_done_ie <= 1'b0;
            r_ovf_ie  <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_oemask  <= '0;
        end else begin
            if (w_csr_wr) begin
                r_en      <= apbs_pwdata[CSR_EN];
                r_done_ie <= apbs_pwdata[CSR_DONE_IE];
                r_ovf_ie  <= apbs_pwdata[CSR_OVF_IE];
            end
            if (w_oem_wr) r_oemask <= apbs_pwdata[N_GPIOS-1:0];
            r_done <= w_done_set | (r_done & ~(w_csr_wr & apbs_pwdata[CSR_DONE]));
            r_ovf  <= w_ovf_set  | (r_ovf  & ~(w_csr_wr & apbs_pwdata[CSR_OVF]));
        end
    end

    always_comb begin
        apbs_prdata = '0;
        case (w_addr)
            ADDR_CSR: apbs_prdata = csr_word(r_en, r_done_ie, r_ovf_ie, r_state == ST_HOLD,
                                             w_full, w_empty, r_done, r_ovf,
                                             CSR_LEVEL_W'(w_level));
            ADDR_OEMASK: apbs_prdata[N_GPIOS-1:0] = r_oemask;
            default: apbs_prdata = '0;
        endcase
    end

endmodule
